// File: rtl/prio_encoder_q_pkg.sv
// prio_enc_pkg
// Shared definitions for the registered priority encoder:
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input
//   idx_width(n)         : index width needed to address n request lines
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_q_rr_pick.sv
// rr_pick
// Purely combinational masked priority search. Scans cand starting at ptr,
// moving upwards and wrapping from N-1 back to 0, and reports the first set
// bit. Passing ptr = 0 turns it into a plain lowest-index-wins encoder.
// Ports:
//   cand  in  N  candidate request vector
//   ptr   in  W  index with the highest priority
//   sel   out W  index of the first set bit found in the scan (0 if none)
//   found out 1  cand is non-zero
//   multi out 1  more than one bit of cand is set
module rr_pick
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         found,
  output logic         multi
);

  int pos;

  // Walk the N positions in priority order. pos wraps once at N rather than
  // at 2^W so non-power-of-two N never scans a nonexistent line; the pos < N
  // guard also keeps an out-of-range ptr harmless.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!found && (pos < N) && cand[pos[W-1:0]]) begin
        found = 1'b1;
        sel   = pos[W-1:0];
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only when at least
  // two bits were set.
  assign multi = |(cand & (cand - N'(1)));

endmodule

// File: rtl/prio_encoder_q.sv
// prio_encoder_q
// Registered N-to-log2(N) priority encoder with request capture and a
// valid/ready output. Requests are folded into a pending vector so nothing is
// lost while the consumer stalls; one pending request is granted per accepted
// transfer, chosen by fixed priority (lowest index) or round-robin.
// N must be at least 2; it need not be a power of two.
// Ports:
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset
//   req        in  N  level request lines
//   mode       in  1  0 = fixed priority, 1 = round-robin
//   out_ready  in  1  consumer accepts the current output
//   out_valid  out 1  out_idx / out_onehot / out_multi are valid
//   out_idx    out W  binary index of the granted request
//   out_onehot out N  one-hot form of out_idx
//   out_multi  out 1  more than one candidate existed at selection time
//   pending    out N  registered pending vector
//   busy       out 1  registered, high when pending is non-zero
module prio_encoder_q
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi,
  output logic [N-1:0] pending,
  output logic         busy
);

  logic [W-1:0] ptr;
  logic [W-1:0] pick_ptr;
  logic [W-1:0] sel;
  logic [W-1:0] ptr_next;
  logic [N-1:0] cand;
  logic [N-1:0] sel_onehot;
  logic [N-1:0] grant_mask;
  logic [N-1:0] pending_next;
  logic         load;
  logic         found;
  logic         multi;

  // Requests arriving this cycle compete alongside those already captured.
  // The output register reloads whenever it is empty or being drained; this
  // is the only place out_ready reaches combinationally.
  assign cand = pending | req;
  assign load = !out_valid || out_ready;

  // Fixed priority is the round-robin search anchored at index 0, so one
  // search block serves both policies.
  assign pick_ptr = (mode == MODE_RR) ? ptr : '0;

  rr_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .cand (cand),
    .ptr  (pick_ptr),
    .sel  (sel),
    .found(found),
    .multi(multi)
  );

  // The granted bit is removed from the captured set, including a request
  // for the same index arriving in this cycle; a request still high next
  // cycle re-arms it. During a stall nothing is granted so pending only grows.
  assign sel_onehot   = N'(1) << sel;
  assign grant_mask   = (load && found) ? sel_onehot : '0;
  assign pending_next = cand & ~grant_mask;

  // Round-robin pointer moves just past the winner, wrapping at the last
  // real line rather than at the top of the index range.
  assign ptr_next = (sel == W'(N - 1)) ? '0 : sel + W'(1);

  // State and output registers. Outputs reload only on load, so a stalled
  // output holds every field. The pointer only advances on round-robin grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      busy       <= 1'b0;
      ptr        <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
    end else begin
      pending <= pending_next;
      busy    <= |pending_next;
      if (load) begin
        out_valid  <= found;
        out_idx    <= found ? sel : '0;
        out_onehot <= found ? sel_onehot : '0;
        out_multi  <= found && multi;
        if (found && (mode == MODE_RR)) begin
          ptr <= ptr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_q.sv
// tb_prio_encoder_q
// Directed bench for prio_encoder_q with an N=8 and an N=5 instance. Each
// expected grant is queued when its stimulus is driven; a monitor pops and
// compares it at every completed transfer (out_valid && out_ready).
module tb_prio_encoder_q;

  typedef struct {
    int idx;
    bit multi;
  } grant_t;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] req8;
  logic       mode8;
  logic       rdy8;
  logic       valid8;
  logic [2:0] idx8;
  logic [7:0] onehot8;
  logic       multi8;
  logic [7:0] pending8;
  logic       busy8;

  logic [4:0] req5;
  logic       mode5;
  logic       rdy5;
  logic       valid5;
  logic [2:0] idx5;
  logic [4:0] onehot5;
  logic       multi5;
  logic [4:0] pending5;
  logic       busy5;

  grant_t q8[$];
  grant_t q5[$];
  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  prio_encoder_q #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req8),
    .mode      (mode8),
    .out_ready (rdy8),
    .out_valid (valid8),
    .out_idx   (idx8),
    .out_onehot(onehot8),
    .out_multi (multi8),
    .pending   (pending8),
    .busy      (busy8)
  );

  prio_encoder_q #(.N(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req5),
    .mode      (mode5),
    .out_ready (rdy5),
    .out_valid (valid5),
    .out_idx   (idx5),
    .out_onehot(onehot5),
    .out_multi (multi5),
    .pending   (pending5),
    .busy      (busy5)
  );

  function automatic logic [31:0] onehotOf(input int idx);
    return 32'd1 << idx;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the N=8 instance for one cycle; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic [7:0] r, input logic m, input logic rd);
    req8  = r;
    mode8 = m;
    rdy8  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus5(input logic [4:0] r);
    req5 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input int idx, input bit m);
    grant_t g;
    g.idx   = idx;
    g.multi = m;
    q8.push_back(g);
  endtask

  task automatic expect5(input int idx, input bit m);
    grant_t g;
    g.idx   = idx;
    g.multi = m;
    q5.push_back(g);
  endtask

  // Scoreboard for N=8: a transfer completes at the next rising edge when
  // valid and ready are both high at the falling edge.
  always @(negedge clk) begin
    grant_t g;
    if (rst_n && valid8 && rdy8) begin
      checkOutput("dut8 grant was expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        g = q8.pop_front();
        checkOutput("dut8 sb idx", 32'(idx8), 32'(g.idx));
        checkOutput("dut8 sb onehot", 32'(onehot8), onehotOf(g.idx));
        checkOutput("dut8 sb multi", 32'(multi8), 32'(g.multi));
      end
    end
  end

  always @(negedge clk) begin
    grant_t g;
    if (rst_n && valid5 && rdy5) begin
      checkOutput("dut5 grant was expected", 32'(q5.size() != 0), 32'd1);
      if (q5.size() != 0) begin
        g = q5.pop_front();
        checkOutput("dut5 sb idx", 32'(idx5), 32'(g.idx));
        checkOutput("dut5 sb onehot", 32'(onehot5), onehotOf(g.idx));
        checkOutput("dut5 sb multi", 32'(multi5), 32'(g.multi));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req8  = '0;
    mode8 = 1'b0;
    rdy8  = 1'b1;
    req5  = '0;
    mode5 = 1'b1;
    rdy5  = 1'b1;

    #2;
    checkOutput("reset valid", 32'(valid8), 0);
    checkOutput("reset idx", 32'(idx8), 0);
    checkOutput("reset pending", 32'(pending8), 0);
    checkOutput("reset busy", 32'(busy8), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] basic encode");
    expect8(2, 0);
    applyStimulus(8'h04, 0, 1);
    checkOutput("t1 valid", 32'(valid8), 1);
    checkOutput("t1 idx", 32'(idx8), 2);
    checkOutput("t1 onehot", 32'(onehot8), 32'h04);
    checkOutput("t1 multi", 32'(multi8), 0);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t1 valid drops", 32'(valid8), 0);
    checkOutput("t1 pending empty", 32'(pending8), 0);

    $display("[TB] fixed priority");
    expect8(1, 1);
    expect8(4, 1);
    expect8(7, 0);
    applyStimulus(8'h92, 0, 1);
    checkOutput("t2 idx first", 32'(idx8), 1);
    checkOutput("t2 pending after first", 32'(pending8), 32'h90);
    checkOutput("t2 busy after first", 32'(busy8), 1);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t2 idx second", 32'(idx8), 4);
    checkOutput("t2 busy after second", 32'(busy8), 1);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t2 idx third", 32'(idx8), 7);
    checkOutput("t2 busy after third", 32'(busy8), 0);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t2 valid drops", 32'(valid8), 0);
    checkOutput("t2 queue drained", 32'(q8.size()), 0);

    $display("[TB] stall and accumulate");
    expect8(0, 0);
    expect8(0, 1);
    expect8(5, 0);
    applyStimulus(8'h01, 0, 0);
    applyStimulus(8'h20, 0, 0);
    applyStimulus(8'h01, 0, 0);
    checkOutput("t3 stall valid", 32'(valid8), 1);
    checkOutput("t3 stall idx", 32'(idx8), 0);
    checkOutput("t3 stall onehot", 32'(onehot8), 32'h01);
    checkOutput("t3 stall multi", 32'(multi8), 0);
    checkOutput("t3 stall pending", 32'(pending8), 32'h21);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t3 rearmed idx", 32'(idx8), 0);
    checkOutput("t3 rearmed multi", 32'(multi8), 1);
    checkOutput("t3 pending left", 32'(pending8), 32'h20);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t3 last idx", 32'(idx8), 5);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t3 valid drops", 32'(valid8), 0);
    checkOutput("t3 queue drained", 32'(q8.size()), 0);

    $display("[TB] grant and request on the same index");
    expect8(1, 0);
    expect8(3, 0);
    expect8(3, 0);
    applyStimulus(8'h02, 0, 0);
    applyStimulus(8'h08, 0, 0);
    checkOutput("t4 pending armed", 32'(pending8), 32'h08);
    applyStimulus(8'h08, 0, 1);
    checkOutput("t4 first idx", 32'(idx8), 3);
    checkOutput("t4 pending merged", 32'(pending8), 0);
    applyStimulus(8'h08, 0, 1);
    checkOutput("t4 second idx", 32'(idx8), 3);
    checkOutput("t4 second pending", 32'(pending8), 0);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t4 valid drops", 32'(valid8), 0);
    checkOutput("t4 queue drained", 32'(q8.size()), 0);

    $display("[TB] async reset mid-stall");
    applyStimulus(8'hF0, 1, 0);
    applyStimulus(8'hF0, 1, 0);
    checkOutput("t5 pre-reset valid", 32'(valid8), 1);
    checkOutput("t5 pre-reset pending", 32'(pending8), 32'hF0);
    req8 = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 reset valid", 32'(valid8), 0);
    checkOutput("t5 reset idx", 32'(idx8), 0);
    checkOutput("t5 reset onehot", 32'(onehot8), 0);
    checkOutput("t5 reset multi", 32'(multi8), 0);
    checkOutput("t5 reset pending", 32'(pending8), 0);
    checkOutput("t5 reset busy", 32'(busy8), 0);
    #3;
    rst_n = 1'b1;
    expect8(0, 1);
    expect8(7, 0);
    applyStimulus(8'h81, 1, 1);
    checkOutput("t5 rr restart idx", 32'(idx8), 0);
    applyStimulus(8'h00, 1, 1);
    checkOutput("t5 rr next idx", 32'(idx8), 7);
    applyStimulus(8'h00, 0, 1);
    checkOutput("t5 valid drops", 32'(valid8), 0);
    checkOutput("t5 queue drained", 32'(q8.size()), 0);

    $display("[TB] round-robin wrap, N=5");
    expect5(0, 1);
    expect5(1, 1);
    expect5(4, 0);
    expect5(0, 1);
    expect5(1, 0);
    applyStimulus5(5'b10011);
    checkOutput("t6 first idx", 32'(idx5), 0);
    applyStimulus5(5'b00000);
    checkOutput("t6 second idx", 32'(idx5), 1);
    applyStimulus5(5'b00000);
    checkOutput("t6 wrap idx", 32'(idx5), 4);
    checkOutput("t6 wrap onehot", 32'(onehot5), 32'h10);
    applyStimulus5(5'b00000);
    checkOutput("t6 valid drops", 32'(valid5), 0);
    applyStimulus5(5'b00011);
    checkOutput("t6 after wrap idx", 32'(idx5), 0);
    checkOutput("t6 after wrap multi", 32'(multi5), 1);
    applyStimulus5(5'b00000);
    checkOutput("t6 final idx", 32'(idx5), 1);
    applyStimulus5(5'b00000);
    checkOutput("t6 final valid", 32'(valid5), 0);
    checkOutput("t6 final pending", 32'(pending5), 0);
    checkOutput("t6 queue drained", 32'(q5.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
